// File: rtl/easyaxi_pkg.sv
// Shared definitions for the EasyAXI slave read path.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package easyaxi_pkg;

    // AXI RRESP encodings used by the slave
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Default widths for the read path
    localparam int DEF_ID_WIDTH   = 4;
    localparam int DEF_LEN_WIDTH  = 8;
    localparam int DEF_DATA_WIDTH = 32;

    // Read-return scheduler FSM encoding
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_BURST = 2'd2
    } rd_state_e;

endpackage

// File: rtl/easyaxi_rr_idx.sv
// Round-robin arbiter: picks one requester per sche_en pulse, starting the search after the last winner.
// Latency: grant_idx is registered at the clock edge where sche_en is high.
// Backpressure: none; grant_idx holds until the next sche_en.
//
// Ports:
//   clk, rst_n  - clock, async active-low reset (search restarts at index 0)
//   sche_en     - take a decision this cycle
//   req         - one request bit per index
//   grant_idx   - registered index of the last winner
module easyaxi_rr_idx #(
    parameter  int DEEP_NUM = 8,
    localparam int IDX_W    = $clog2(DEEP_NUM)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sche_en,
    input  logic [DEEP_NUM-1:0] req,
    output logic [IDX_W-1:0]    grant_idx
);

    logic [IDX_W-1:0] start_q;
    logic [IDX_W-1:0] pick;
    logic [IDX_W-1:0] cand;
    logic             found;

    // Walk the request vector starting at start_q; DEEP_NUM is a power of
    // two, so plain IDX_W-bit addition gives the wrap-around for free.
    always_comb begin
        pick  = start_q;
        cand  = start_q;
        found = 1'b0;
        for (int i = 0; i < DEEP_NUM; i++) begin
            cand = start_q + IDX_W'(i);
            if (!found && req[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_idx <= '0;
            start_q   <= '0;
        end else if (sche_en && found) begin
            grant_idx <= pick;
            start_q   <= pick + IDX_W'(1);
        end
    end

endmodule

// File: rtl/easyaxi_rd_sched.sv
// Read-data return scheduler: shares the AXI R channel among outstanding read entries, one whole burst at a time.
// Latency: entry valid seen in IDLE at cycle 0 gives rvalid in cycle 2; two dead cycles between bursts.
// Backpressure: rready low holds rid/rresp/rlast/buf_raddr (hence rdata); the grant stays locked until the last beat.
//
// Ports:
//   clk, rst_n    - clock, async active-low reset (partial burst dropped, no done pulse)
//   entry_*_i     - per-entry ready flag, ARID, ARLEN, error flag from the outstanding table
//   buf_raddr_o   - read buffer address {entry_ptr, beat_cnt}; buf_rdata_i returns combinationally
//   r*_o/rready_i - AXI R channel
//   entry_done_o  - one-hot single-cycle pulse when an entry's burst has fully handshaken
module easyaxi_rd_sched
    import easyaxi_pkg::*;
#(
    parameter  int OST_DEPTH  = 8,
    parameter  int ID_WIDTH   = DEF_ID_WIDTH,
    parameter  int LEN_WIDTH  = DEF_LEN_WIDTH,
    parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
    localparam int PTR_W      = $clog2(OST_DEPTH)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [OST_DEPTH-1:0]           entry_vld_i,
    input  logic [OST_DEPTH*ID_WIDTH-1:0]  entry_id_i,
    input  logic [OST_DEPTH*LEN_WIDTH-1:0] entry_len_i,
    input  logic [OST_DEPTH-1:0]           entry_err_i,
    output logic [PTR_W+LEN_WIDTH-1:0]     buf_raddr_o,
    input  logic [DATA_WIDTH-1:0]          buf_rdata_i,
    output logic                           rvalid_o,
    input  logic                           rready_i,
    output logic [ID_WIDTH-1:0]            rid_o,
    output logic [DATA_WIDTH-1:0]          rdata_o,
    output logic [1:0]                     rresp_o,
    output logic                           rlast_o,
    output logic [OST_DEPTH-1:0]           entry_done_o
);

    rd_state_e             state_q;
    rd_state_e             state_d;
    logic                  sche_en;
    logic                  load_en;
    logic                  beat_fire;
    logic                  burst_end;

    logic [PTR_W-1:0]      grant_idx;
    logic [PTR_W-1:0]      entry_ptr_q;
    logic [ID_WIDTH-1:0]   id_q;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  beat_cnt_q;
    logic                  err_q;
    logic                  rvalid_q;
    logic [OST_DEPTH-1:0]  done_q;
    logic                  last_beat;

    easyaxi_rr_idx #(
        .DEEP_NUM (OST_DEPTH)
    ) u_rr_idx (
        .clk       (clk),
        .rst_n     (rst_n),
        .sche_en   (sche_en),
        .req       (entry_vld_i),
        .grant_idx (grant_idx)
    );

    // The burst ends on the compare, so beat_cnt never has to wrap even for
    // the maximum ARLEN.
    assign last_beat = (beat_cnt_q == len_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sche_en   = 1'b0;
        load_en   = 1'b0;
        beat_fire = 1'b0;
        burst_end = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|entry_vld_i) begin
                    sche_en = 1'b1;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                load_en = 1'b1;
                state_d = ST_BURST;
            end
            ST_BURST: begin
                if (rready_i) begin
                    if (last_beat) begin
                        burst_end = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        beat_fire = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Entry attributes are captured once at LOAD; upstream keeps them stable
    // until the done pulse, but latching keeps the R channel independent of it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry_ptr_q <= '0;
            id_q        <= '0;
            len_q       <= '0;
            err_q       <= 1'b0;
            beat_cnt_q  <= '0;
        end else if (load_en) begin
            entry_ptr_q <= grant_idx;
            id_q        <= entry_id_i[grant_idx*ID_WIDTH +: ID_WIDTH];
            len_q       <= entry_len_i[grant_idx*LEN_WIDTH +: LEN_WIDTH];
            err_q       <= entry_err_i[grant_idx];
            beat_cnt_q  <= '0;
        end else if (beat_fire) begin
            beat_cnt_q  <= beat_cnt_q + LEN_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_q <= 1'b0;
            done_q   <= '0;
        end else begin
            done_q <= '0;
            if (load_en) begin
                rvalid_q <= 1'b1;
            end else if (burst_end) begin
                rvalid_q            <= 1'b0;
                done_q[entry_ptr_q] <= 1'b1;
            end
        end
    end

    assign buf_raddr_o  = {entry_ptr_q, beat_cnt_q};
    assign rdata_o      = buf_rdata_i;
    assign rvalid_o     = rvalid_q;
    assign rid_o        = id_q;
    // Gated by rvalid so rlast/rresp read as zero between bursts.
    assign rresp_o      = (rvalid_q && err_q) ? RESP_SLVERR : RESP_OKAY;
    assign rlast_o      = rvalid_q && last_beat;
    assign entry_done_o = done_q;

endmodule

// File: tb/tb_easyaxi_rd_sched.sv
module tb_easyaxi_rd_sched;

    localparam int N  = 8;
    localparam int IW = 4;
    localparam int LW = 8;
    localparam int DW = 32;
    localparam int PW = 3;
    localparam int AW = PW + LW;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    entry_vld;
    logic [N*IW-1:0] entry_id;
    logic [N*LW-1:0] entry_len;
    logic [N-1:0]    entry_err;
    logic [AW-1:0]   buf_raddr;
    logic [DW-1:0]   buf_rdata;
    logic            rvalid;
    logic            rready;
    logic [IW-1:0]   rid;
    logic [DW-1:0]   rdata;
    logic [1:0]      rresp;
    logic            rlast;
    logic [N-1:0]    entry_done;

    // upstream stimulus state
    logic [N-1:0]    vld_q;
    logic [N-1:0]    rearm;
    logic            refill;
    logic [IW-1:0]   id_a  [N];
    logic [LW-1:0]   len_a [N];
    logic [N-1:0]    err_v;

    // scoreboard / counters
    int              total;
    int              bad;
    int              hs_cnt;
    int              done_cnt;
    int              rlast_cnt;
    int              slverr_cnt;
    int              stall_cnt;
    logic [N-1:0]    done_or;
    int              grants[$];
    logic            prev_rvalid;

    // behavioural model of the R channel
    bit              m_busy;
    bit              m_load;
    int              m_ent;
    int              m_beat;
    int              m_next;
    logic [N-1:0]    m_done;

    always #5 clk = ~clk;

    always_comb begin
        entry_id  = '0;
        entry_len = '0;
        for (int k = 0; k < N; k++) begin
            entry_id[k*IW +: IW]  = id_a[k];
            entry_len[k*LW +: LW] = len_a[k];
        end
    end

    assign entry_vld = vld_q;
    assign entry_err = err_v;
    assign buf_rdata = {21'h1ABCD, buf_raddr};

    easyaxi_rd_sched #(
        .OST_DEPTH  (N),
        .ID_WIDTH   (IW),
        .LEN_WIDTH  (LW),
        .DATA_WIDTH (DW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .entry_vld_i  (entry_vld),
        .entry_id_i   (entry_id),
        .entry_len_i  (entry_len),
        .entry_err_i  (entry_err),
        .buf_raddr_o  (buf_raddr),
        .buf_rdata_i  (buf_rdata),
        .rvalid_o     (rvalid),
        .rready_i     (rready),
        .rid_o        (rid),
        .rdata_o      (rdata),
        .rresp_o      (rresp),
        .rlast_o      (rlast),
        .entry_done_o (entry_done)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Called at the falling edge: compare this cycle's outputs with the model,
    // then advance the model with the inputs the DUT will sample next edge.
    task automatic model_step();
        logic [AW-1:0] ea;
        if (!rst_n) begin
            m_busy      = 1'b0;
            m_load      = 1'b0;
            m_next      = 0;
            m_done      = '0;
            prev_rvalid = 1'b0;
            return;
        end

        check("rvalid", rvalid, m_busy);
        check("entry_done", entry_done, m_done);
        if (m_busy) begin
            ea = {PW'(m_ent), LW'(m_beat)};
            check("rid", rid, id_a[m_ent]);
            check("rresp", rresp, err_v[m_ent] ? 2'b10 : 2'b00);
            check("rlast", rlast, m_beat == int'(len_a[m_ent]));
            check("buf_raddr", buf_raddr, ea);
            check("rdata", rdata, {21'h1ABCD, ea});
        end else begin
            check("rlast_idle", rlast, 1'b0);
        end
        if (m_busy || m_load) begin
            assert (entry_vld[m_ent])
            else $error("protocol: granted entry %0d dropped its valid before done", m_ent);
        end

        if (rvalid && !prev_rvalid) grants.push_back(int'(buf_raddr[AW-1:LW]));
        prev_rvalid = rvalid;
        if (rvalid && rready) begin
            hs_cnt++;
            if (rlast) rlast_cnt++;
            if (rresp == 2'b10) slverr_cnt++;
        end
        if (rvalid && !rready) stall_cnt++;
        done_cnt += $countones(entry_done);
        done_or  |= entry_done;

        m_done = '0;
        if (m_busy) begin
            if (rready) begin
                if (m_beat == int'(len_a[m_ent])) begin
                    m_busy        = 1'b0;
                    m_done[m_ent] = 1'b1;
                end else begin
                    m_beat++;
                end
            end
        end else if (m_load) begin
            m_load = 1'b0;
            m_busy = 1'b1;
            m_beat = 0;
        end else if (entry_vld != '0) begin
            for (int i = 0; i < N; i++) begin
                if (!m_load && entry_vld[(m_next + i) % N]) begin
                    m_ent  = (m_next + i) % N;
                    m_load = 1'b1;
                end
            end
            m_next = (m_ent + 1) % N;
        end
    endtask

    // One clock: model/compare at negedge, then upstream reacts just after
    // the rising edge (frees done entries, optionally re-arms them a cycle later).
    task automatic tick();
        logic [N-1:0] freed;
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
        freed = vld_q & entry_done;
        vld_q = (vld_q & ~entry_done) | rearm;
        rearm = refill ? freed : '0;
    endtask

    task automatic drain(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (vld_q == '0 && rearm == '0 && !m_busy && !m_load) begin
                ok = 1'b1;
                break;
            end
        end
        check(name, ok, 1'b1);
        tick();
        tick();
    endtask

    task automatic wait_rvalid(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (rvalid) begin
                seen = 1'b1;
                break;
            end
        end
        check(name, seen, 1'b1);
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        vld_q  = '0;
        rearm  = '0;
        refill = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    function automatic int grant_at(input int idx);
        return (idx < grants.size()) ? grants[idx] : -1;
    endfunction

    initial begin
        int s, h0, d0, l0, e0, st0;
        int exp2 [9];
        exp2 = '{0, 1, 2, 3, 4, 5, 6, 7, 0};

        total = 0; bad = 0;
        hs_cnt = 0; done_cnt = 0; rlast_cnt = 0; slverr_cnt = 0; stall_cnt = 0;
        done_or = '0; prev_rvalid = 1'b0;
        m_busy = 1'b0; m_load = 1'b0; m_ent = 0; m_beat = 0; m_next = 0; m_done = '0;
        for (int k = 0; k < N; k++) begin
            id_a[k]  = IW'(k + 3);
            len_a[k] = '0;
        end
        err_v  = '0;
        vld_q  = '0;
        rearm  = '0;
        refill = 1'b0;
        rready = 1'b1;
        rst_n  = 1'b0;

        // reset state
        tick();
        tick();
        check("rst_rvalid", rvalid, 1'b0);
        check("rst_rlast", rlast, 1'b0);
        check("rst_rid", rid, 4'h0);
        check("rst_rresp", rresp, 2'b00);
        check("rst_done", entry_done, 8'h00);
        check("rst_raddr", buf_raddr, 11'h000);
        rst_n = 1'b1;
        tick();

        // 1: single burst on entry 2, id 5, 4 beats
        len_a[2] = 8'd3;
        s = grants.size(); h0 = hs_cnt; l0 = rlast_cnt; d0 = done_cnt; done_or = '0;
        vld_q = 8'h04;
        tick();
        check("t1_rvalid_cycle1", rvalid, 1'b0);
        tick();
        check("t1_rvalid_cycle2", rvalid, 1'b1);
        check("t1_raddr_beat0", buf_raddr, 11'h200);
        check("t1_rid", rid, 4'h5);
        check("t1_rlast_beat0", rlast, 1'b0);
        drain("t1_drain");
        check("t1_handshakes", hs_cnt - h0, 4);
        check("t1_rlast_count", rlast_cnt - l0, 1);
        check("t1_done_pulses", done_cnt - d0, 1);
        check("t1_done_vector", done_or, 8'h04);
        check("t1_grant", grant_at(s), 2);
        len_a[2] = '0;

        // 2: fairness, all entries valid, len 0, re-asserted after done
        do_reset();
        s = grants.size();
        refill = 1'b1;
        vld_q  = 8'hFF;
        for (int i = 0; i < 200 && grants.size() < s + 9; i++) tick();
        refill = 1'b0;
        drain("t2_drain");
        for (int i = 0; i < 9; i++) check("t2_grant_order", grant_at(s + i), exp2[i]);

        // 3: rotation after entry 3 was served
        do_reset();
        s = grants.size();
        vld_q = 8'h08;
        drain("t3_drain_a");
        vld_q = 8'h22;
        drain("t3_drain_b");
        check("t3_first", grant_at(s), 3);
        check("t3_second", grant_at(s + 1), 5);
        check("t3_third", grant_at(s + 2), 1);

        // 4: backpressure on a 3-beat burst
        len_a[4] = 8'd2;
        rready = 1'b0;
        h0 = hs_cnt; d0 = done_cnt; st0 = stall_cnt; done_or = '0;
        vld_q = 8'h10;
        wait_rvalid("t4_rvalid_wait");
        foreach (exp2[i]) begin
            if (i < 6) begin
                rready = (i == 1 || i == 4 || i == 5);
                tick();
            end
        end
        check("t4_rvalid_end", rvalid, 1'b0);
        rready = 1'b1;
        drain("t4_drain");
        check("t4_handshakes", hs_cnt - h0, 3);
        check("t4_done_pulses", done_cnt - d0, 1);
        check("t4_stalls", stall_cnt - st0, 3);
        check("t4_done_vector", done_or, 8'h10);
        len_a[4] = '0;

        // 5: error entry gives SLVERR on both beats
        err_v[6] = 1'b1;
        len_a[6] = 8'd1;
        h0 = hs_cnt; e0 = slverr_cnt;
        vld_q = 8'h40;
        drain("t5_drain");
        check("t5_slverr_beats", slverr_cnt - e0, 2);
        check("t5_handshakes", hs_cnt - h0, 2);
        err_v[6] = 1'b0;
        len_a[6] = '0;

        // 6: reset in the middle of an 8-beat burst
        do_reset();
        len_a[3] = 8'd7;
        d0 = done_cnt; done_or = '0;
        vld_q = 8'h08;
        wait_rvalid("t6_rvalid_wait");
        tick();
        tick();
        check("t6_beat2_addr", buf_raddr, 11'h302);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rvalid_async", rvalid, 1'b0);
        check("t6_rlast_async", rlast, 1'b0);
        vld_q = '0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("t6_no_done", done_cnt - d0, 0);
        check("t6_done_vector", done_or, 8'h00);
        len_a[3] = '0;
        s = grants.size();
        vld_q = 8'h21;
        drain("t6_drain");
        check("t6_first_after_reset", grant_at(s), 0);
        check("t6_second_after_reset", grant_at(s + 1), 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
